mips_muldiv: RTL and testbench
==============================

MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 supported.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, reset: synchronous, active-high; clock clk.
REQ-004 SHALL have port start, input, 1, launches operation from rs_val/rt_val when sampled with busy=0.
REQ-005 SHALL have port op, input, 2, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports rs_val and rt_val, input, 32 each; register-file read data, multiplicand/dividend and multiplier/divisor.
REQ-007 SHALL have ports hi_we and lo_we, input, 1 each; MTHI/MTLO write strobes.
REQ-008 SHALL have port wdata, input, 32, MTHI/MTLO data.
REQ-009 SHALL have port busy, output, 1, operation in progress.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have ports hi and lo, output, 32 each, HI/LO registers.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> FIN -> IDLE; IDLE->RUN on start; RUN->FIN after 32 iterations; FIN->IDLE unconditionally.
REQ-013 SHALL accept start only in IDLE; start during RUN/FIN ignored, no queueing.
REQ-014 SHALL latch operands and op at accept edge E0; busy=1 from E0 through E33.
REQ-015 SHALL perform one iteration per RUN cycle, edges E1..E32: shift-add multiply, restoring divide.
REQ-016 SHALL, at E33 (FIN), write hi/lo and assert done for exactly one cycle with busy=0 in that cycle.
REQ-017 SHALL produce the 64-bit product {hi,lo} for MULT/MULTU; signed ops work on magnitudes, result negated when operand signs differ.
REQ-018 SHALL produce lo=quotient, hi=remainder for DIV/DIVU; quotient truncates toward zero; remainder sign equals dividend sign.
REQ-019 SHALL handle divide by zero: lo=0xFFFFFFFF, hi=rs_val; normal 34-edge latency; no exception.
REQ-020 SHALL handle DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-021 SHALL write hi from wdata on hi_we and lo on lo_we at the next edge, only when busy=0 and not in FIN.
REQ-022 SHALL ignore hi_we/lo_we while busy=1.
REQ-023 SHALL, on start with hi_we/lo_we in the same IDLE cycle, perform both; the write is visible until FIN overwrites it.
REQ-024 SHALL leave hi/lo unchanged during RUN; they hold prior values until FIN.

Reset
REQ-025 SHALL, at the reset edge, set state=IDLE, hi=0, lo=0, busy=0, done=0, and iteration counter=0.
REQ-026 SHALL abort any in-flight operation on reset; no done pulse follows.
REQ-027 SHALL give reset priority over start, hi_we and lo_we.

Configuration
REQ-028 SHALL compile the divider when MIPS_MULDIV_DIV_EN is defined; ops 10/11 then behave per REQ-018..020.
REQ-029 SHALL, when MIPS_MULDIV_DIV_EN is undefined, omit divider logic; start with op[1]=1 is ignored, busy stays 0, hi/lo unchanged, no done.

Structure
REQ-030 SHALL take op encodings, FSM state encoding and XLEN from shared package mips_pkg.
REQ-031 SHALL be a single module with no sub-modules; operand magnitude/negate logic stays inline.

Verification
REQ-032 SHALL test MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at E33 hi=0xFFFFFFFE, lo=0x00000001, done one cycle.
REQ-033 SHALL test MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-034 SHALL test DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
REQ-035 SHALL test start at E0, second start at E5 and hi_we at E10 -> second start and write ignored; single done at E33 with first result.
REQ-036 SHALL test reset asserted at E15 of a MULT -> hi=lo=0, busy=0; no done within 40 cycles.
REQ-037 SHALL test idle MTLO 0x12345678 -> lo=0x12345678 next cycle; without MIPS_MULDIV_DIV_EN, DIV start -> busy stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    // Operand/result width; the datapath only supports 32.
    localparam int MIPS_XLEN = 32;

    // Operation encodings presented on the op port.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    // Sequencer states: idle, one iteration per RUN cycle, result write-back.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers (divider built only with MIPS_MULDIV_DIV_EN).
// Latency: start accepted at edge E0, HI/LO written and done pulsed at E33 (34 edges total).
// Backpressure: start only accepted while idle; start and MTHI/MTLO strobes are dropped while busy.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int XLEN = MIPS_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [XLEN-1:0]     r_a;          // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   r_p;          // product accumulator or {remainder, dividend/quotient}
    logic                r_neg_res;    // operand signs differ: negate product / quotient

    logic                w_op_ok;
    logic                w_accept;
    logic                w_signed;
    logic                w_rs_neg;
    logic                w_rt_neg;
    logic [XLEN-1:0]     w_rs_mag;
    logic [XLEN-1:0]     w_rt_mag;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_nxt;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_hi_res;
    logic [XLEN-1:0]     w_lo_res;

`ifdef MIPS_MULDIV_DIV_EN
    logic                r_is_div;
    logic                r_neg_rem;    // remainder takes the dividend's sign
    logic                r_dz;         // divisor was zero
    logic [XLEN:0]       w_div_sh;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_rem;
    logic [2*XLEN-1:0]   w_div_nxt;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;

    assign w_op_ok = 1'b1;
`else
    // Without the divider, divide ops are simply never accepted.
    assign w_op_ok = ~op[1];
`endif

    assign w_accept = start && (r_state == ST_IDLE) && w_op_ok;
    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_rs_neg = w_signed && rs_val[XLEN-1];
    assign w_rt_neg = w_signed && rt_val[XLEN-1];
    assign w_rs_mag = w_rs_neg ? -rs_val : rs_val;
    assign w_rt_mag = w_rt_neg ? -rt_val : rt_val;

    // Shift-add step: add multiplicand into the upper half when the current multiplier bit is set, then shift right.
    assign w_mul_sum = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_a} : '0);
    assign w_mul_nxt = {w_mul_sum, r_p[XLEN-1:1]};
    assign w_prod    = r_neg_res ? -r_p : r_p;

`ifdef MIPS_MULDIV_DIV_EN
    // Restoring step: shift next dividend bit into the remainder, subtract divisor if it fits.
    assign w_div_sh  = r_p[2*XLEN-1:XLEN-1];
    assign w_div_ge  = (w_div_sh >= {1'b0, r_a});
    assign w_div_rem = w_div_ge ? (w_div_sh[XLEN-1:0] - r_a) : w_div_sh[XLEN-1:0];
    assign w_div_nxt = {w_div_rem, r_p[XLEN-2:0], w_div_ge};
    assign w_quo     = r_p[XLEN-1:0];
    assign w_rem     = r_p[2*XLEN-1:XLEN];
`endif

    // Final sign fix-up of the iterated magnitudes into HI/LO values.
    always_comb begin
        w_hi_res = w_prod[2*XLEN-1:XLEN];
        w_lo_res = w_prod[XLEN-1:0];
`ifdef MIPS_MULDIV_DIV_EN
        if (r_is_div) begin
            // A zero divisor yields all-ones quotient and the dividend as remainder.
            w_lo_res = r_dz ? '1 : (r_neg_res ? -w_quo : w_quo);
            w_hi_res = r_neg_rem ? -w_rem : w_rem;
        end
`endif
    end

    // State register and iteration counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == ST_RUN)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Next-state: leave RUN after the last of XLEN iterations; FIN always returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == CW'(XLEN-1)) w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Busy covers both the iteration and the write-back cycle.
    always_comb begin
        busy = (r_state != ST_IDLE);
    end

    // Operand capture at accept, then one iteration per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= '0;
            r_p       <= '0;
            r_neg_res <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
            r_is_div  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
`endif
        end else if (w_accept) begin
            r_neg_res <= w_rs_neg ^ w_rt_neg;
`ifdef MIPS_MULDIV_DIV_EN
            r_is_div  <= op[1];
            r_neg_rem <= w_rs_neg;
            r_dz      <= (rt_val == '0);
            if (op[1]) begin
                r_a <= w_rt_mag;
                r_p <= {{XLEN{1'b0}}, w_rs_mag};
            end else begin
                r_a <= w_rs_mag;
                r_p <= {{XLEN{1'b0}}, w_rt_mag};
            end
`else
            r_a <= w_rs_mag;
            r_p <= {{XLEN{1'b0}}, w_rt_mag};
`endif
        end else if (r_state == ST_RUN) begin
`ifdef MIPS_MULDIV_DIV_EN
            r_p <= r_is_div ? w_div_nxt : w_mul_nxt;
`else
            r_p <= w_mul_nxt;
`endif
        end
    end

    // HI/LO: result write-back in FIN, MTHI/MTLO only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (r_state == ST_FIN) begin
            hi <= w_hi_res;
            lo <= w_lo_res;
        end else if (r_state == ST_IDLE) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

    // One-cycle completion pulse following the write-back edge.
    always_ff @(posedge clk) begin
        if (reset)
            done <= 1'b0;
        else
            done <= (r_state == ST_FIN);
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: multiply/divide results, timing, ignored strobes, reset abort.
// Latency: expects done and HI/LO update at E33 after the accept edge E0.
// Backpressure: checks that start and MTHI/MTLO are dropped while busy.
module tb_mips_muldiv;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mips_muldiv #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Launch one op and verify busy/hold/done timing and the {hi,lo} result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        tick(1);                                   // E0
        start = 1'b0;
        check({tag, "_busy_e0"}, {63'd0, busy}, 64'd1);
        tick(32);                                  // E32
        check({tag, "_busy_e32"}, {63'd0, busy}, 64'd1);
        check({tag, "_hold_e32"}, {hi, lo}, {m_hi, m_lo});
        tick(1);                                   // E33
        check({tag, "_done"}, {62'd0, done, busy}, 64'd2);
        check({tag, "_res"}, {hi, lo}, exp_res);
        m_hi = exp_res[63:32];
        m_lo = exp_res[31:0];
        tick(1);
        check({tag, "_done_off"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n_done;
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

        // Reset state
        tick(2);
        reset = 1'b0;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);

        // Idle MTLO / MTHI
        lo_we = 1'b1; wdata = 32'h1234_5678;
        tick(1);
        lo_we = 1'b0;
        check("mtlo", {hi, lo}, {32'h0, 32'h1234_5678});
        hi_we = 1'b1; wdata = 32'hCAFE_F00D;
        tick(1);
        hi_we = 1'b0;
        check("mthi", {hi, lo}, {32'hCAFE_F00D, 32'h1234_5678});
        m_hi = 32'hCAFE_F00D; m_lo = 32'h1234_5678;

        // Multiplies
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_m3x7", OP_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult_min2", OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("mult_mix",  OP_MULT,  32'd12345,     -32'sd1000,    64'hFFFF_FFFF_FF43_A158);

        // Second start at E5 and MTHI at E10 are ignored while busy
        op = OP_MULTU; rs_val = 32'd3; rt_val = 32'd5; start = 1'b1;
        tick(1);                                   // E0
        start = 1'b0;
        tick(4);                                   // E4
        op = OP_MULT; rs_val = 32'd9; rt_val = 32'd9; start = 1'b1;
        tick(1);                                   // E5
        start = 1'b0;
        check("ign_busy_e5", {63'd0, busy}, 64'd1);
        tick(4);                                   // E9
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        tick(1);                                   // E10
        hi_we = 1'b0;
        check("ign_mthi", {32'd0, hi}, {32'd0, m_hi});
        n_done = 0;
        for (int i = 11; i <= 33; i++) begin
            tick(1);
            if (done) n_done++;
        end
        check("ign_done_e33", {63'd0, done}, 64'd1);
        check("ign_res", {hi, lo}, {32'd0, 32'd15});
        for (int i = 34; i <= 45; i++) begin
            tick(1);
            if (done) n_done++;
        end
        check("ign_single_done", 64'(n_done), 64'd1);
        check("ign_idle", {63'd0, busy}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd15;

        // Start with MTHI in the same idle cycle: write visible until FIN overwrites it
        op = OP_MULTU; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
        hi_we = 1'b1; wdata = 32'hAAAA_5555;
        tick(1);                                   // E0
        start = 1'b0; hi_we = 1'b0;
        check("both_mthi", {32'd0, hi}, {32'd0, 32'hAAAA_5555});
        tick(32);
        check("both_hold", {hi, lo}, {32'hAAAA_5555, 32'd15});
        tick(1);                                   // E33
        check("both_res", {hi, lo}, {32'd0, 32'd6});
        m_hi = 32'd0; m_lo = 32'd6;

`ifdef MIPS_MULDIV_DIV_EN
        // Divides
        run_op("div_m7_2",   OP_DIV,  -32'sd7,      32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_dz",    OP_DIVU, 32'd100,      32'd0,         {32'd100, 32'hFFFF_FFFF});
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("div_7_m2",   OP_DIV,  32'd7,        -32'sd2,       64'h0000_0001_FFFF_FFFD);
        run_op("divu_big",   OP_DIVU, 32'hFFFF_FFFF, 32'd10,       64'h0000_0005_1999_9999);
        run_op("div_dz_neg", OP_DIV,  -32'sd5,      32'd0,         64'hFFFF_FFFB_FFFF_FFFF);
`else
        // Divide ops are not accepted without the divider
        op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
        tick(1);
        start = 1'b0;
        check("nodiv_busy", {63'd0, busy}, 64'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (done || busy) n_done++;
        end
        check("nodiv_quiet", 64'(n_done), 64'd0);
        check("nodiv_hilo", {hi, lo}, {m_hi, m_lo});
`endif

        // Reset at E15 aborts a MULT with no done afterwards
        op = OP_MULT; rs_val = 32'd1000; rt_val = 32'd1000; start = 1'b1;
        tick(1);                                   // E0
        start = 1'b0;
        tick(14);                                  // E14
        reset = 1'b1;
        tick(1);                                   // E15
        reset = 1'b0;
        check("rstmid_hilo", {hi, lo}, 64'd0);
        check("rstmid_busy_done", {62'd0, busy, done}, 64'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (done) n_done++;
        end
        check("rstmid_nodone", 64'(n_done), 64'd0);
        check("rstmid_idle", {63'd0, busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
